// File: rtl/ariane_pkg.sv
// ariane_pkg: shared dcache constants and the flush-walker state encoding.
//   DCACHE_NUM_SETS / DCACHE_NUM_WAYS : default dcache geometry (powers of two, >= 2)
//   flush_state_e                     : dcache_flush_walker FSM states
package ariane_pkg;

    localparam int unsigned DCACHE_NUM_SETS = 256;
    localparam int unsigned DCACHE_NUM_WAYS = 4;

    typedef enum logic [2:0] {
        FlushIdle,
        FlushRead,
        FlushCheck,
        FlushWb,
        FlushUpdate,
        FlushAck
    } flush_state_e;

endpackage

// File: rtl/dcache_flush_walker.sv
// dcache_flush_walker: walks every (set, way) of the dcache on a flush request, writes back
// dirty lines, strobes a tag update for each handled line, then acks the flush.
//
// Ports
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   flush_i                     : flush request, sampled only while idle
//   flush_ack_o                 : one-cycle pulse once the whole cache has been walked
//   busy_o                      : high in every state except idle
//   tag_req_o                   : tag read strobe for (set_o, way_o)
//   set_o, way_o                : current line index
//   tag_valid_i, tag_dirty_i    : line state, one cycle after tag_req_o
//   wb_valid_o, wb_ready_i      : writeback handshake for (set_o, way_o)
//   upd_o                       : one-cycle tag update strobe for (set_o, way_o)
//
// Build option: DCACHE_FLUSH_INVALIDATE_EN
//   defined   : upd_o clears valid and dirty; valid clean lines also get an update
//   undefined : upd_o clears dirty only; clean lines are skipped
module dcache_flush_walker
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_SETS = DCACHE_NUM_SETS,
    parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    output logic                        flush_ack_o,
    output logic                        busy_o,
    output logic                        tag_req_o,
    output logic [$clog2(NUM_SETS)-1:0] set_o,
    output logic [$clog2(NUM_WAYS)-1:0] way_o,
    input  logic                        tag_valid_i,
    input  logic                        tag_dirty_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic                        upd_o
);

    localparam int unsigned SetW = $clog2(NUM_SETS);
    localparam int unsigned WayW = $clog2(NUM_WAYS);
    localparam logic [SetW-1:0] LastSet = SetW'(NUM_SETS - 1);
    localparam logic [WayW-1:0] LastWay = WayW'(NUM_WAYS - 1);

`ifdef DCACHE_FLUSH_INVALIDATE_EN
    localparam bit CleanUpdate = 1'b1;
`else
    localparam bit CleanUpdate = 1'b0;
`endif

    flush_state_e    state_d, state_q;
    logic [SetW-1:0] set_d, set_q;
    logic [WayW-1:0] way_d, way_q;
    logic            advance;

    assign set_o = set_q;
    assign way_o = way_q;

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        way_d       = way_q;
        advance     = 1'b0;
        tag_req_o   = 1'b0;
        wb_valid_o  = 1'b0;
        upd_o       = 1'b0;
        flush_ack_o = 1'b0;
        busy_o      = (state_q != FlushIdle);

        unique case (state_q)
            FlushIdle: begin
                if (flush_i) begin
                    state_d = FlushRead;
                    set_d   = '0;
                    way_d   = '0;
                end
            end
            FlushRead: begin
                tag_req_o = 1'b1;
                state_d   = FlushCheck;
            end
            FlushCheck: begin
                if (tag_valid_i && tag_dirty_i) begin
                    state_d = FlushWb;
                end else if (tag_valid_i && CleanUpdate) begin
                    state_d = FlushUpdate;
                end else begin
                    advance = 1'b1;
                end
            end
            FlushWb: begin
                // Request stays up with a stable index until the writeback is accepted.
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    state_d = FlushUpdate;
                end
            end
            FlushUpdate: begin
                upd_o   = 1'b1;
                advance = 1'b1;
            end
            FlushAck: begin
                flush_ack_o = 1'b1;
                state_d     = FlushIdle;
            end
            default: state_d = FlushIdle;
        endcase

        // Way-major walk; both counters wrap naturally at their width, so after the last
        // line they are back at (0, 0) for the next flush.
        if (advance) begin
            way_d = way_q + WayW'(1);
            if (way_q == LastWay) begin
                set_d = set_q + SetW'(1);
            end
            state_d = (set_q == LastSet && way_q == LastWay) ? FlushAck : FlushRead;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FlushIdle;
            set_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

endmodule

// File: tb/tb_dcache_flush_walker.sv
// Scoreboard bench for dcache_flush_walker (4 sets x 2 ways). Directed scenarios push the
// expected writeback / update / ack events; a negedge monitor models the tag array and the
// writeback sink, and pops/compares each event the DUT presents.
module tb_dcache_flush_walker;

    localparam int unsigned NS = 4;
    localparam int unsigned NW = 2;
    localparam int KWb  = 0;
    localparam int KUpd = 1;
    localparam int KAck = 2;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
    localparam bit InvEn = 1'b1;
`else
    localparam bit InvEn = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       flush_ack_o;
    logic       busy_o;
    logic       tag_req_o;
    logic [1:0] set_o;
    logic [0:0] way_o;
    logic       tag_valid_i;
    logic       tag_dirty_i;
    logic       wb_valid_o;
    logic       wb_ready_i;
    logic       upd_o;

    dcache_flush_walker #(
        .NUM_SETS (NS),
        .NUM_WAYS (NW)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .flush_ack_o (flush_ack_o),
        .busy_o      (busy_o),
        .tag_req_o   (tag_req_o),
        .set_o       (set_o),
        .way_o       (way_o),
        .tag_valid_i (tag_valid_i),
        .tag_dirty_i (tag_dirty_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .upd_o       (upd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int kind;
        int s;
        int w;
        int n;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  wb_delay = 0;
    int  wb_cnt = 0;
    int  walk_cyc = 0;
    bit  mem_v[NS][NW];
    bit  mem_d[NS][NW];

    task automatic push_ev(input int kind, input int s, input int w, input int n);
        ev_t e;
        e.kind = kind;
        e.s    = s;
        e.w    = w;
        e.n    = n;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int s, input int w, input int n);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d set=%0d way=%0d n=%0d, required no event",
                     kind, s, w, n);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.s != s || e.w != w || e.n != n) begin
                bad++;
                $display("FAIL event: got kind=%0d set=%0d way=%0d n=%0d, required kind=%0d set=%0d way=%0d n=%0d",
                         kind, s, w, n, e.kind, e.s, e.w, e.n);
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int outs();
        return int'({flush_ack_o, busy_o, tag_req_o, set_o, way_o, wb_valid_o, upd_o});
    endfunction

    task automatic clear_mem();
        for (int s = 0; s < int'(NS); s++) begin
            for (int w = 0; w < int'(NW); w++) begin
                mem_v[s][w] = 1'b0;
                mem_d[s][w] = 1'b0;
            end
        end
    endtask

    // Tag array + writeback sink model, and the scoreboard monitor.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            walk_cyc    = 0;
            wb_cnt      = 0;
            wb_ready_i  = 1'b0;
            tag_valid_i = 1'b0;
            tag_dirty_i = 1'b0;
        end else begin
            if (busy_o) walk_cyc++;
            if (tag_req_o) begin
                tag_valid_i = mem_v[set_o][way_o];
                tag_dirty_i = mem_d[set_o][way_o];
            end
            if (wb_valid_o) begin
                wb_ready_i = (wb_cnt >= wb_delay);
                wb_cnt++;
            end else begin
                wb_ready_i = 1'b0;
                wb_cnt     = 0;
            end
            if (wb_valid_o && wb_ready_i) check_ev(KWb, int'(set_o), int'(way_o), wb_cnt);
            if (upd_o) begin
                check_ev(KUpd, int'(set_o), int'(way_o), 0);
                mem_d[set_o][way_o] = 1'b0;
                if (InvEn) mem_v[set_o][way_o] = 1'b0;
            end
            if (flush_ack_o) check_ev(KAck, 0, 0, walk_cyc);
            if (!busy_o) walk_cyc = 0;
        end
    end

    task automatic run_walk(input int drop_after);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        flush_i = 1'b1;
        while (!seen && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            if (drop_after > 0 && cyc == drop_after) flush_i = 1'b0;
            if (flush_ack_o) seen = 1'b1;
        end
        flush_i = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack in %0d cycles, required an ack", cyc);
        end
    endtask

    task automatic finish_walk(input string name);
        repeat (3) @(negedge clk_i);
        check_int({name, "_events_left"}, exp_q.size(), 0);
        check_int({name, "_busy_after"}, int'(busy_o), 0);
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk_i);
        check_int("reset_outputs", outs(), 0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check_int("idle_busy", int'(busy_o), 0);

        // All lines invalid: ack on the 17th busy cycle, no writeback, no update.
        clear_mem();
        push_ev(KAck, 0, 0, 17);
        run_walk(0);
        finish_walk("t1");

        // Line (2,1) dirty, ready after 5 cycles: 6-cycle writeback then one update.
        clear_mem();
        mem_v[2][1] = 1'b1;
        mem_d[2][1] = 1'b1;
        wb_delay = 5;
        push_ev(KWb, 2, 1, 6);
        push_ev(KUpd, 2, 1, 0);
        push_ev(KAck, 0, 0, 24);
        run_walk(0);
        finish_walk("t2");
        check_int("t2_dirty_cleared", int'(mem_d[2][1]), 0);
        check_int("t2_valid_after", int'(mem_v[2][1]), InvEn ? 0 : 1);

        // flush_i dropped after 3 cycles: walk still completes with one ack.
        clear_mem();
        mem_v[1][0] = 1'b1;
        mem_d[1][0] = 1'b1;
        wb_delay = 0;
        push_ev(KWb, 1, 0, 1);
        push_ev(KUpd, 1, 0, 0);
        push_ev(KAck, 0, 0, 19);
        run_walk(3);
        repeat (30) @(negedge clk_i);
        finish_walk("t3");

        // Reset during writeback: outputs clear, no ack, next flush restarts at (0,0).
        clear_mem();
        mem_v[0][1] = 1'b1;
        mem_d[0][1] = 1'b1;
        wb_delay = 100;
        flush_i = 1'b1;
        cnt = 0;
        while (!wb_valid_o && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
        end
        check_int("t4_wb_entered", int'(wb_valid_o), 1);
        check_int("t4_wb_set", int'(set_o), 0);
        check_int("t4_wb_way", int'(way_o), 1);
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_int("t4_reset_outputs", outs(), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        check_int("t4_idle_busy", int'(busy_o), 0);
        check_int("t4_no_events", exp_q.size(), 0);
        wb_delay = 0;
        push_ev(KWb, 0, 1, 1);
        push_ev(KUpd, 0, 1, 0);
        push_ev(KAck, 0, 0, 19);
        flush_i = 1'b1;
        cnt = 0;
        while (!tag_req_o && cnt < 10) begin
            @(negedge clk_i);
            cnt++;
        end
        check_int("t4_restart_req", int'(tag_req_o), 1);
        check_int("t4_restart_set", int'(set_o), 0);
        check_int("t4_restart_way", int'(way_o), 0);
        run_walk(0);
        finish_walk("t4");

        // All lines valid and clean: 8 updates only in the invalidating build.
        for (int s = 0; s < int'(NS); s++) begin
            for (int w = 0; w < int'(NW); w++) begin
                mem_v[s][w] = 1'b1;
                mem_d[s][w] = 1'b0;
                if (InvEn) push_ev(KUpd, s, w, 0);
            end
        end
        push_ev(KAck, 0, 0, InvEn ? 25 : 17);
        run_walk(0);
        finish_walk("t5");
        cnt = 0;
        for (int s = 0; s < int'(NS); s++) begin
            for (int w = 0; w < int'(NW); w++) begin
                if (mem_v[s][w]) cnt++;
            end
        end
        check_int("t5_valid_lines", cnt, InvEn ? 0 : 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
